// File: rtl/instr_encoder_loader.sv
// Encodes symbolic MIPS requests into 32-bit words and writes them sequentially into instruction memory.
// Optional macro DELAY_SLOT_PAD_EN appends a NOP after every beq/j.
module instr_encoder_loader #(
  parameter int ADDR_W = 10,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  input  logic              req_last,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              err_illegal,
  output logic [ADDR_W:0]   word_count
);

`ifdef DELAY_SLOT_PAD_EN
  localparam logic PAD_EN = 1'b1;
`else
  localparam logic PAD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t          state, state_nxt;
  logic [ADDR_W:0] wr_ptr;
  logic            full, accept, pad_pending, last_pend, done_pend;
  logic            legal, branch;
  logic [31:0]     enc;

  // wr_ptr reaches 2**ADDR_W exactly when the top address has been written
  assign full      = wr_ptr[ADDR_W];
  assign req_ready = (state == LOAD) && !pad_pending && !full;
  assign accept    = req_valid && req_ready;
  assign busy      = (state == LOAD);

  always_comb begin
    legal  = 1'b1;
    branch = 1'b0;
    enc    = 32'h0;
    case (req_op)
      4'd0: enc = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100001};
      4'd1: enc = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100011};
      4'd2: enc = {6'b001101, req_rs, req_rt, req_imm};
      4'd3: enc = {6'b100011, req_rs, req_rt, req_imm};
      4'd4: enc = {6'b101011, req_rs, req_rt, req_imm};
      4'd5: begin
        enc    = {6'b000100, req_rs, req_rt, req_imm};
        branch = 1'b1;
      end
      4'd6: enc = {6'b001111, 5'b00000, req_rt, req_imm};
      4'd7: begin
        enc    = {6'b000010, req_target};
        branch = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        if (start)
          state_nxt = LOAD;
        else if (pad_pending) begin
          if (full || last_pend) state_nxt = DONE;
        end else if (accept && req_last && !(PAD_EN && legal && branch))
          state_nxt = DONE;
        else if (req_valid && full)
          state_nxt = DONE;
      end
      DONE: if (start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im_we       <= 1'b0;
      im_addr     <= ADDR_W'(BASE);
      im_wdata    <= 32'h0;
      wr_ptr      <= (ADDR_W+1)'(BASE);
      word_count  <= '0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      err_illegal <= 1'b0;
      pad_pending <= 1'b0;
      last_pend   <= 1'b0;
      done_pend   <= 1'b0;
    end else begin
      im_we     <= 1'b0;
      done_pend <= 1'b0;
      // done rises one cycle after the final word's write cycle
      done      <= done | done_pend;
      if (start) begin
        wr_ptr      <= (ADDR_W+1)'(BASE);
        word_count  <= '0;
        done        <= 1'b0;
        overflow    <= 1'b0;
        err_illegal <= 1'b0;
        pad_pending <= 1'b0;
        last_pend   <= 1'b0;
      end else if (state == LOAD) begin
        if (pad_pending) begin
          pad_pending <= 1'b0;
          last_pend   <= 1'b0;
          if (full) begin
            overflow <= 1'b1;
          end else begin
            im_we      <= 1'b1;
            im_addr    <= wr_ptr[ADDR_W-1:0];
            im_wdata   <= 32'h0;
            wr_ptr     <= wr_ptr + 1'b1;
            word_count <= word_count + 1'b1;
            done_pend  <= last_pend;
          end
        end else if (accept) begin
          if (legal) begin
            im_we      <= 1'b1;
            im_addr    <= wr_ptr[ADDR_W-1:0];
            im_wdata   <= enc;
            wr_ptr     <= wr_ptr + 1'b1;
            word_count <= word_count + 1'b1;
            if (PAD_EN && branch) begin
              pad_pending <= 1'b1;
              last_pend   <= req_last;
            end else begin
              done_pend <= req_last;
            end
          end else begin
            err_illegal <= 1'b1;
            if (req_last) done <= 1'b1;
          end
        end else if (req_valid && full) begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed and randomized checks of instr_encoder_loader against a word-list reference model.
module tb_instr_encoder_loader;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;
`ifdef DELAY_SLOT_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;
  } req_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic req_valid = 1'b0, req_ready, req_last = 1'b0;
  logic [3:0] req_op = '0;
  logic [4:0] req_rs = '0, req_rt = '0, req_rd = '0;
  logic [15:0] req_imm = '0;
  logic [25:0] req_target = '0;
  logic im_we, busy, done, overflow, err_illegal;
  logic [AW-1:0] im_addr;
  logic [31:0] im_wdata;
  logic [AW:0] word_count;

  int total = 0, bad = 0;
  logic [31:0] wq_d[$];
  int          wq_a[$];

  instr_encoder_loader #(.ADDR_W(AW), .BASE(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
    .req_target(req_target), .req_last(req_last), .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .busy(busy), .done(done), .overflow(overflow),
    .err_illegal(err_illegal), .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n && im_we) begin
      wq_a.push_back(int'(im_addr));
      wq_d.push_back(im_wdata);
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] encode(input req_t r);
    logic [31:0] rs = 32'(r.rs) << 21, rt = 32'(r.rt) << 16, rd = 32'(r.rd) << 11;
    logic [31:0] imm = 32'(r.imm);
    case (r.op)
      4'd0: return rs + rt + rd + 33;
      4'd1: return rs + rt + rd + 35;
      4'd2: return (32'd13 << 26) + rs + rt + imm;
      4'd3: return (32'd35 << 26) + rs + rt + imm;
      4'd4: return (32'd43 << 26) + rs + rt + imm;
      4'd5: return (32'd4 << 26) + rs + rt + imm;
      4'd6: return (32'd15 << 26) + rt + imm;
      4'd7: return (32'd2 << 26) + 32'(r.tgt);
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wq_a.delete(); wq_d.delete();
  endtask

  task automatic send(input req_t r, input logic last, output logic acc);
    acc = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_op = r.op; req_rs = r.rs; req_rt = r.rt; req_rd = r.rd;
    req_imm = r.imm; req_target = r.tgt; req_last = last;
    for (int k = 0; k < 6; k++) begin
      if (req_ready) begin
        @(posedge clk);
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic drop();
    @(negedge clk); req_valid = 1'b0; req_last = 1'b0;
  endtask

  function automatic req_t mk(input int op, input int rs, input int rt, input int rd, input int imm);
    req_t r;
    r.op = 4'(op); r.rs = 5'(rs); r.rt = 5'(rt); r.rd = 5'(rd); r.imm = 16'(imm);
    r.tgt = 26'h0;
    return r;
  endfunction

  initial begin
    req_t r, prog[$];
    logic acc;
    logic [31:0] exp_w[$];
    int n_acc, ptr, len, wait_n;
    bit refused, e_done, e_ovf, e_ill;

    // reset state
    #12;
    chk("rst_ready", req_ready, 0);   chk("rst_we", im_we, 0);
    chk("rst_busy", busy, 0);         chk("rst_done", done, 0);
    chk("rst_addr", im_addr, 0);      chk("rst_wdata", im_wdata, 0);
    chk("rst_wc", word_count, 0);     chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;

    // addu: latency 1 write
    pulse_start();
    chk("busy_load", busy, 1);
    send(mk(0, 1, 2, 3, 0), 1'b0, acc);
    #1;
    chk("addu_acc", acc, 1);  chk("addu_we", im_we, 1);
    chk("addu_addr", im_addr, 0); chk("addu_data", im_wdata, 32'h00221821);
    chk("addu_wc", word_count, 1);
    drop();

    // ori then lui(last), done one cycle after final write
    pulse_start();
    send(mk(2, 0, 8, 0, 16'h00FF), 1'b0, acc);
    send(mk(6, 0, 9, 0, 16'h1234), 1'b1, acc);
    #1;
    chk("lui_we", im_we, 1); chk("lui_addr", im_addr, 1);
    chk("lui_data", im_wdata, 32'h3C091234);
    chk("lui_done_early", done, 0); chk("lui_busy", busy, 0);
    @(posedge clk); #1;
    chk("lui_done", done, 1);
    chk("ori_first", wq_d.size() > 0 ? wq_d[0] : 32'hX, 32'h340800FF);
    drop();

    // illegal op between two sw
    pulse_start();
    send(mk(4, 1, 2, 0, 4), 1'b0, acc);
    send(mk(12, 3, 3, 3, 3), 1'b0, acc);
    chk("ill_acc", acc, 1);
    send(mk(4, 1, 5, 0, 8), 1'b1, acc);
    drop(); drop();
    chk("ill_flag", err_illegal, 1);
    chk("ill_nw", wq_a.size(), 2);
    chk("ill_a1", wq_a.size() > 1 ? wq_a[1] : -1, 1);
    chk("ill_d1", wq_d.size() > 1 ? wq_d[1] : 32'hX, 32'hAC250008);

    // fill memory with valid held: DEPTH writes, next refused
    pulse_start();
    for (int i = 0; i < DEPTH; i++) send(mk(1, i, i, i, 0), 1'b0, acc);
    send(mk(1, 9, 9, 9, 0), 1'b0, acc);
    chk("full_refused", acc, 0);
    chk("full_ovf", overflow, 1); chk("full_done", done, 0);
    chk("full_nw", wq_a.size(), DEPTH);
    chk("full_lasta", wq_a.size() > 0 ? wq_a[wq_a.size()-1] : -1, DEPTH - 1);
    drop();

`ifdef DELAY_SLOT_PAD_EN
    pulse_start();
    send(mk(5, 1, 2, 0, 16'hFFFE), 1'b0, acc);
    #1;
    chk("pad_ready_low", req_ready, 0);
    chk("pad_br", im_wdata, 32'h1022FFFE);
    drop(); drop();
    chk("pad_nw", wq_a.size(), 2);
    chk("pad_nop", wq_d.size() > 1 ? wq_d[1] : 32'hX, 32'h0);
`endif

    // randomized programs against the word-list model
    for (int it = 0; it < 40; it++) begin
      prog.delete(); exp_w.delete();
      len = $urandom_range(1, DEPTH + 3);
      for (int i = 0; i < len; i++) begin
        r.op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
        r.rs = 5'($urandom); r.rt = 5'($urandom); r.rd = 5'($urandom);
        r.imm = 16'($urandom); r.tgt = 26'($urandom);
        prog.push_back(r);
      end
      ptr = 0; n_acc = 0; refused = 0; e_done = 0; e_ovf = 0; e_ill = 0;
      for (int i = 0; i < len; i++) begin
        if (ptr == DEPTH) begin e_ovf = 1; refused = 1; break; end
        n_acc++;
        if (prog[i].op > 7) e_ill = 1;
        else begin
          exp_w.push_back(encode(prog[i])); ptr++;
          if (PAD && (prog[i].op == 5 || prog[i].op == 7)) begin
            if (ptr == DEPTH) begin e_ovf = 1; break; end
            exp_w.push_back(32'h0); ptr++;
          end
        end
        if (i == len - 1) e_done = 1;
      end

      pulse_start();
      for (int i = 0; i < n_acc; i++) begin
        send(prog[i], i == len - 1, acc);
        if (!acc) chk("rnd_accept", acc, 1);
        if ($urandom_range(0, 2) == 0) drop();
      end
      if (refused) begin
        send(prog[n_acc], n_acc == len - 1, acc);
        chk("rnd_refused", acc, 0);
      end
      drop();
      wait_n = 0;
      while (!(done || overflow) && wait_n < 20) begin @(negedge clk); wait_n++; end
      if (wait_n >= 20) chk("rnd_timeout", 1, 0);
      drop(); drop();

      chk("rnd_nw", wq_a.size(), exp_w.size());
      for (int i = 0; i < exp_w.size() && i < wq_a.size(); i++) begin
        if (wq_a[i] != i) chk("rnd_addr", wq_a[i], i);
        if (wq_d[i] !== exp_w[i]) chk("rnd_data", wq_d[i], exp_w[i]);
      end
      chk("rnd_wc", word_count, exp_w.size());
      chk("rnd_done", done, e_done);
      chk("rnd_ovf", overflow, e_ovf);
      chk("rnd_ill", err_illegal, e_ill);
      chk("rnd_busy", busy, 0);
    end

    // asynchronous reset while a write is in flight
    pulse_start();
    send(mk(0, 4, 5, 6, 0), 1'b0, acc);
    #1;
    chk("mid_we_pre", im_we, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_we", im_we, 0);     chk("mid_busy", busy, 0);
    chk("mid_ready", req_ready, 0); chk("mid_addr", im_addr, 0);
    chk("mid_wdata", im_wdata, 0); chk("mid_wc", word_count, 0);
    drop();
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
